mux_arb_n: RTL and testbench
============================

Name: mux_arb_n

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output and a valid/ready handshake on every channel.
- Runtime mode select:
  - FIXED: software-style select, as in a plain 4:1 mux.
  - RR: round-robin arbitration across requesting channels.
- Used wherever several single-bit or bus sources share one downstream consumer; one-cycle latency; full throughput.

Parameters:
- N_CH, 4, number of input channels (>=2).
- DW, 8, data width per channel in bits (>=1).
- SELW, $clog2(N_CH), select/channel-index width; derived localparam, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset; assertion clears state immediately, deassertion synchronous to clk.
- mode  in  1  0 = FIXED (use sel), 1 = RR (round-robin).
- sel  in  SELW  channel select in FIXED mode; ignored in RR.
- in_valid  in  N_CH  per-channel request; bit i belongs to channel i.
- in_data  in  N_CH*DW  packed data; channel i at bits [i*DW +: DW].
- in_ready  out  N_CH  per-channel accept, one-hot or zero.
- out_valid  out  1  output register holds a word.
- out_data  out  DW  registered data.
- out_ch  out  SELW  index of the channel that produced out_data.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
- in_ready is combinational; while rst_n=0 it is all-zero.
- load_en = !out_valid || out_ready; the output slot is free or draining this cycle.
- Grant (combinational, at most one channel):
  - FIXED: grant = sel if sel < N_CH and in_valid[sel]; otherwise no grant. An out-of-range sel never grants and never errors.
  - RR: grant = first i with in_valid[i], searching rr_ptr, rr_ptr+1, ..., wrapping modulo N_CH. No grant if in_valid == 0.
- in_ready[i] = load_en && grant valid && i == grant.
- Transfer on channel i is in_valid[i] && in_ready[i].
- On transfer at edge k:
  - out_data = in_data[grant], out_ch = grant, out_valid = 1, visible at edge k+1 (latency 1 cycle).
- No transfer:
  - If out_valid && out_ready, out_valid -> 0.
  - If out_valid && !out_ready, out_valid, out_data and out_ch hold exactly.
- rr_ptr:
  - Updates only on a transfer while mode=1: rr_ptr = grant+1, with N_CH-1 wrapping to 0.
  - Holds in FIXED mode and on cycles with no transfer.
- Mode or sel changes take effect in the same cycle's grant. rr_ptr is retained across mode changes.
- Simultaneous drain and load (out_valid && out_ready && grant): new word loads; out_valid stays 1. Throughput is 1 word/cycle.
- Starvation bound in RR with out_ready=1: a continuously requesting channel is granted within N_CH transfers.
- Reset mid-operation: an in-flight output word is discarded and rr_ptr returns to 0. No in_ready asserts during reset.
- Data is never modified. Width mismatches are not possible: all slices are exactly DW.

Decomposition:
- Package mux_arb_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1 constants.
  - Function for the packed-slice index.
- One sub-module: rr_pick. Parametrised N_CH; inputs req[N_CH] and start[SELW]; outputs gnt_idx[SELW] and gnt_vld. It is a rotating-priority encoder, purely combinational.
- The top holds the output register, rr_ptr and the FIXED/RR grant mux.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_ch=0; release -> first RR grant is channel 0.
- FIXED select, N_CH=4, DW=8:
  - Setup: mode=0, sel=2, in_data = {8'hD3,8'hC2,8'hB1,8'hA0}, all valid, out_ready=1.
  - Required: in_ready=4'b0100 each cycle; out_data=8'hC2, out_ch=2 one cycle later.
  - Then sel=1 -> next word 8'hB1.
- RR fairness: mode=1, in_valid=4'b1011, out_ready=1 for 6 cycles -> out_ch sequence 0,1,3,0,1,3; channel 2 never granted.
- Backpressure:
  - Setup: out_ready=0 after the first load of 8'hA0.
  - Required: out_valid=1 and out_data=8'hA0 held; in_ready=0 for all channels.
  - On out_ready=1: the next word loads in the same cycle, with no bubble.
- Out-of-range sel, N_CH=3: sel=3 with in_valid=3'b111 -> in_ready=0, out_valid falls to 0 after drain, no X on outputs.
- Mid-operation reset, RR:
  - Setup: assert rst_n=0 asynchronously between edges after grants 0,1.
  - Required: out_valid drops immediately; after release, the first grant is channel 0, not 2.

Source files
------------

// File: rtl/mux_arb_n_pkg.sv
// Shared constants and helpers for the N-channel arbitrated mux.
// Imported by the interface consumers and the top.
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int slice_lo(input int idx, input int dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// Channel-side and output-side handshake bundle for mux_arb_n.
// master drives requests/data; slave is the arbiter.
interface mux_arb_n_if #(
    parameter int N_CH = 4,
    parameter int DW   = 8
);
    localparam int SELW = $clog2(N_CH);

    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [N_CH-1:0]      in_valid;
    logic [N_CH*DW-1:0]   in_data;
    logic [N_CH-1:0]      in_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_ready;

    modport master (
        output mode,
        output sel,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch
    );

    modport slave (
        input  mode,
        input  sel,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch
    );

endinterface

// File: rtl/mux_arb_n_rr_pick.sv
// Rotating-priority encoder: first set req bit at or after start,
// wrapping modulo N_CH. Purely combinational.
module rr_pick #(
    parameter int N_CH = 4,
    localparam int SELW = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SELW-1:0] start,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_vld
);

    logic [SELW-1:0] idx;

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = SELW'((int'(start) + k) % N_CH);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel registered mux with FIXED select or round-robin grant,
// one-cycle latency and full throughput.
module mux_arb_n #(
    parameter int N_CH = 4,
    parameter int DW   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_arb_n_if.slave   bus
);

    import mux_arb_pkg::*;

    localparam int SELW = $clog2(N_CH);
    localparam int NPAD = 2 ** SELW;

    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] rr_idx;
    logic            rr_vld;
    logic [SELW-1:0] gnt;
    logic            gnt_vld;
    logic            load_en;
    logic            xfer;
    logic [NPAD-1:0] vld_pad;
    logic [DW-1:0]   gnt_data;
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;
    logic [SELW-1:0] out_ch_q;

    rr_pick #(
        .N_CH (N_CH)
    ) u_pick (
        .req     (bus.in_valid),
        .start   (rr_ptr),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    // Zero-padding makes an out-of-range sel read a 0 request bit.
    always_comb begin
        vld_pad = NPAD'(bus.in_valid);
        gnt     = bus.sel;
        gnt_vld = vld_pad[bus.sel];
        if (bus.mode == MODE_RR) begin
            gnt     = rr_idx;
            gnt_vld = rr_vld;
        end
        load_en  = !out_valid_q || bus.out_ready;
        xfer     = rst_n && load_en && gnt_vld;
        gnt_data = bus.in_data[slice_lo(int'(gnt), DW) +: DW];
    end

    always_comb begin
        bus.in_ready = '0;
        if (xfer) begin
            bus.in_ready[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr      <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= gnt_data;
            out_ch_q    <= gnt;
            if (bus.mode == MODE_RR) begin
                rr_ptr <= (gnt == SELW'(N_CH - 1)) ? '0 : gnt + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed and random checks of mux_arb_n against a behavioural model.
// A second 3-channel instance covers the out-of-range select.
module tb_mux_arb_n;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux_arb_n_if #(.N_CH(4), .DW(8)) a ();
    mux_arb_n_if #(.N_CH(3), .DW(8)) b ();

    mux_arb_n #(.N_CH(4), .DW(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a.slave)
    );

    mux_arb_n #(.N_CH(3), .DW(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state of the 4-channel instance
    bit         m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ch    = 0;
        m_ptr   = 0;
    endtask

    // Channel that should win this cycle, or -1 when none
    function automatic int exp_grant();
        if (a.mode == 1'b0) begin
            if (int'(a.sel) < 4 && a.in_valid[a.sel]) return int'(a.sel);
            return -1;
        end
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (a.in_valid[c]) return c;
        end
        return -1;
    endfunction

    // Called just after an edge with inputs already driven.
    task automatic step();
        int         g;
        bit         load;
        logic [3:0] er;
        #3;
        g    = exp_grant();
        load = !m_valid || a.out_ready;
        er   = (load && g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("in_ready", 32'(a.in_ready), 32'(er));
        @(posedge clk);
        if (load && g >= 0) begin
            m_valid = 1'b1;
            m_data  = a.in_data[g*8 +: 8];
            m_ch    = g;
            if (a.mode) m_ptr = (g + 1) % 4;
        end else if (a.out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", 32'(a.out_valid), 32'(m_valid));
        chk("out_data", 32'(a.out_data), 32'(m_data));
        chk("out_ch", 32'(a.out_ch), 32'(m_ch));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_out_valid", 32'(a.out_valid), 32'(0));
        chk("rst_in_ready", 32'(a.in_ready), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int seq[6];
        seq = '{0, 1, 3, 0, 1, 3};

        rst_n       = 1'b0;
        a.mode      = 1'b1;
        a.sel       = 2'd0;
        a.in_valid  = 4'b1111;
        a.in_data   = 32'hD3C2B1A0;
        a.out_ready = 1'b1;
        b.mode      = 1'b0;
        b.sel       = 2'd0;
        b.in_valid  = 3'b000;
        b.in_data   = 24'h0;
        b.out_ready = 1'b1;
        model_reset();

        // Reset values with every channel requesting
        #2;
        chk("rst_in_ready", 32'(a.in_ready), 32'(0));
        chk("rst_out_valid", 32'(a.out_valid), 32'(0));
        chk("rst_out_data", 32'(a.out_data), 32'(0));
        chk("rst_out_ch", 32'(a.out_ch), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("first_rr_ch", 32'(a.out_ch), 32'(0));

        // FIXED select
        a.mode = 1'b0;
        a.sel  = 2'd2;
        step();
        chk("fixed_sel2_data", 32'(a.out_data), 32'h0C2);
        step();
        chk("fixed_sel2_ch", 32'(a.out_ch), 32'(2));
        a.sel = 2'd1;
        step();
        chk("fixed_sel1_data", 32'(a.out_data), 32'h0B1);

        // RR fairness, channel 2 idle
        do_reset();
        a.mode     = 1'b1;
        a.in_valid = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_seq", 32'(a.out_ch), 32'(seq[i]));
        end

        // Backpressure hold then no-bubble reload
        a.mode     = 1'b0;
        a.sel      = 2'd0;
        a.in_valid = 4'b1111;
        step();
        chk("bp_first", 32'(a.out_data), 32'h0A0);
        a.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_data", 32'(a.out_data), 32'h0A0);
            chk("bp_hold_valid", 32'(a.out_valid), 32'(1));
        end
        a.out_ready = 1'b1;
        a.sel       = 2'd1;
        step();
        chk("bp_release_data", 32'(a.out_data), 32'h0B1);
        chk("bp_release_valid", 32'(a.out_valid), 32'(1));

        // Mid-operation asynchronous reset in RR
        do_reset();
        a.mode = 1'b1;
        step();
        step();
        chk("mid_pre_ch", 32'(a.out_ch), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_valid", 32'(a.out_valid), 32'(0));
        chk("mid_in_ready", 32'(a.in_ready), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("mid_first_ch", 32'(a.out_ch), 32'(0));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            a.mode      = 1'($urandom_range(0, 1));
            a.sel       = 2'($urandom_range(0, 3));
            a.in_valid  = 4'($urandom_range(0, 15));
            a.in_data   = $urandom;
            a.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Out-of-range select on the 3-channel instance
        b.in_data  = 24'h332211;
        b.in_valid = 3'b111;
        b.sel      = 2'd1;
        #3;
        chk("b_in_ready_sel1", 32'(b.in_ready), 32'(3'b010));
        @(posedge clk);
        #1;
        chk("b_load_valid", 32'(b.out_valid), 32'(1));
        chk("b_load_data", 32'(b.out_data), 32'h022);
        b.sel = 2'd3;
        for (int i = 0; i < 2; i++) begin
            #3;
            chk("b_oor_in_ready", 32'(b.in_ready), 32'(0));
            @(posedge clk);
            #1;
            chk("b_oor_valid", 32'(b.out_valid), 32'(0));
            chk("b_oor_data", 32'(b.out_data), 32'h022);
            chk("b_oor_ch", 32'(b.out_ch), 32'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
